// File: rtl/axi_read_channel.sv
// AXI4-style read-only slave: accepts one AR request at a time and streams
// arlen+1 R beats from a fixed pattern memory (word i = {16'hCAFE, i}).
module axi_read_channel #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [2:0]            arprot,
  input  logic [3:0]            arlen,
  input  logic [1:0]            arsize,
  input  logic [2:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);

  typedef enum logic {IDLE, BURST} state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  state_e                  state_q;
  logic                    arready_q, rvalid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              rresp_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [3:0]              len_q, beat_q;
  logic [1:0]              size_q;
  logic [2:0]              burst_q;
  logic [2:0]              prot_q, prot_d;
  logic                    err_q;

  logic [ADDR_WIDTH-1:0]   beat_addr;
  logic [ADDR_WIDTH-3:0]   beat_idx;
  logic                    beat_err;
  logic [DATA_WIDTH-1:0]   beat_data;
  logic [1:0]              beat_resp;
  logic                    ar_hs;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a, input logic [3:0] len,
    input logic [1:0] size, input logic [2:0] burst);
    logic [ADDR_WIDTH-1:0] s, b;
    s = ADDR_WIDTH'(1) << size;
    b = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * s;
    case (burst)
      3'd1:    next_addr = a + s;
      3'd2:    next_addr = (a & ~(b - 1'b1)) | ((a + s) & (b - 1'b1));
      default: next_addr = a;  // FIXED; reserved encodings also hold the address
    endcase
  endfunction

  function automatic logic slv_err(
    input logic [ADDR_WIDTH-1:0] a, input logic [3:0] len,
    input logic [1:0] size, input logic [2:0] burst);
    logic [ADDR_WIDTH-1:0] s;
    logic wrap;
    s    = ADDR_WIDTH'(1) << size;
    wrap = (burst == 3'd2);
    slv_err = (size == 2'd3) || (burst > 3'd2) ||
              (wrap && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) ||
              (wrap && ((a & (s - 1'b1)) != '0));
  endfunction

  assign ar_hs = arvalid && arready_q;
  assign prot_d = ar_hs ? arprot : prot_q;

  // Beat 0 comes straight from the AR inputs; later beats from the latched state.
  always_comb begin
    beat_addr = (state_q == IDLE) ? araddr : addr_q;
    beat_err  = (state_q == IDLE) ? slv_err(araddr, arlen, arsize, arburst) : err_q;
    beat_idx  = beat_addr[ADDR_WIDTH-1:2];
    beat_data = '0;
    beat_resp = RESP_OKAY;
    if (beat_idx >= (ADDR_WIDTH-2)'(MEM_DEPTH)) begin
      beat_resp = RESP_DECERR;
    end else if (beat_err) begin
      beat_resp = RESP_SLVERR;
    end else begin
      beat_data = DATA_WIDTH'({16'hCAFE, beat_idx[15:0]});
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      prot_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      prot_q <= prot_d;
      case (state_q)
        IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            addr_q    <= next_addr(araddr, arlen, arsize, arburst);
            len_q     <= arlen;
            size_q    <= arsize;
            burst_q   <= arburst;
            err_q     <= beat_err;
            beat_q    <= '0;
            rvalid_q  <= 1'b1;
            rdata_q   <= beat_data;
            rresp_q   <= beat_resp;
            arready_q <= 1'b0;
            state_q   <= BURST;
          end
        end
        BURST: begin
          if (rready) begin
            if (beat_q == len_q) begin
              rvalid_q  <= 1'b0;
              arready_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              rdata_q <= beat_data;
              rresp_q <= beat_resp;
              addr_q  <= next_addr(addr_q, len_q, size_q, burst_q);
              beat_q  <= beat_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_read_channel.sv
// Directed plus randomized bursts against a queue-based reference of the
// address/response rules; checks reset, latency, backpressure and errors.
module tb_axi_read_channel;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic [3:0]  arlen;
  logic [1:0]  arsize;
  logic [2:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] mem [256];
  logic [33:0] exp_q [$];

  axi_read_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256)) dut (
    .aclk(aclk), .aresetn(aresetn), .araddr(araddr), .arprot(arprot),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .rready(rready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    n_assert++;
    n_fail++;
    $error("FAIL %s: timed out waiting for DUT", tag);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Reference: list of {resp, data} per beat from the burst rules.
  task automatic model(input logic [31:0] addr, input int len, input int size, input int burst);
    int unsigned s, b, a, idx;
    bit err;
    exp_q.delete();
    s = 1 << size;
    b = (len + 1) * s;
    err = (size == 3) || (burst > 2) ||
          (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
          (burst == 2 && (addr % s) != 0);
    a = addr;
    for (int k = 0; k <= len; k++) begin
      idx = a >> 2;
      if (idx >= 256)  exp_q.push_back({2'b11, 32'h0});
      else if (err)    exp_q.push_back({2'b10, 32'h0});
      else             exp_q.push_back({2'b00, mem[idx]});
      if (burst == 1)      a = a + s;
      else if (burst == 2) a = (a & ~(b - 1)) | ((a + s) & (b - 1));
    end
  endtask

  task automatic do_burst(input logic [31:0] addr, input int len, input int size,
                          input int burst, input int hold, input int stall_beat,
                          input int stall_cyc, input bit rnd);
    int k, cyc, st, h;
    model(addr, len, size, burst);
    araddr  = addr;
    arlen   = 4'(len);
    arsize  = 2'(size);
    arburst = 3'(burst);
    arprot  = 3'($urandom);
    arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < 20) begin step(); cyc++; end
    if (!arready) begin
      tmo("ar_wait");
      arvalid = 1'b0;
      return;
    end
    step();
    h = hold - 1;
    if (h <= 0) arvalid = 1'b0;
    chk("arready_busy", arready, 0);
    k = 0; st = 0; cyc = 0;
    while (k <= len && cyc < 300) begin
      chk("rvalid", rvalid, 1);
      chk("rdata", rdata, exp_q[k][31:0]);
      chk("rresp", rresp, exp_q[k][33:32]);
      if (rnd) rready = ($urandom_range(0, 3) != 0);
      else if (k == stall_beat && st < stall_cyc) begin rready = 1'b0; st++; end
      else rready = 1'b1;
      step();
      cyc++;
      if (arvalid) begin h--; if (h <= 0) arvalid = 1'b0; end
      if (rready) k++;
    end
    if (k <= len) tmo("r_beats");
    rready  = 1'b0;
    arvalid = 1'b0;
    chk("rvalid_end", rvalid, 0);
    chk("arready_end", arready, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {16'hCAFE, 16'(i)};
    aresetn = 1'b0; araddr = '0; arprot = '0; arlen = '0; arsize = '0;
    arburst = '0; arvalid = 1'b0; rready = 1'b0;
    step();
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);
    aresetn = 1'b1;
    step();
    chk("idle_arready", arready, 1);
    chk("idle_rvalid", rvalid, 0);

    do_burst(32'h4, 2, 2, 1, 2, -1, 0, 0);     // INCR, arvalid held 2 cycles
    do_burst(32'h8, 2, 2, 1, 1, -1, 0, 0);
    do_burst(32'hC, 3, 2, 2, 1, -1, 0, 0);     // WRAP 16B
    do_burst(32'h10, 3, 2, 1, 1, 1, 3, 0);     // stall 3 cycles on beat 1
    do_burst(32'h400, 0, 2, 1, 1, -1, 0, 0);   // DECERR
    do_burst(32'h0, 1, 2, 5, 1, -1, 0, 0);     // reserved burst -> SLVERR
    do_burst(32'h20, 3, 2, 0, 1, -1, 0, 0);    // FIXED
    do_burst(32'h3F8, 3, 2, 1, 1, -1, 0, 0);   // INCR crosses into DECERR
    do_burst(32'h0, 1, 3, 1, 1, -1, 0, 0);     // 8-byte size -> SLVERR
    do_burst(32'h4, 2, 2, 2, 1, -1, 0, 0);     // WRAP bad length -> SLVERR

    // Reset in the middle of a burst
    araddr = 32'h0; arlen = 4'd7; arsize = 2'd2; arburst = 3'd1; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    rready  = 1'b1;
    step();
    step();
    chk("mid_rvalid", rvalid, 1);
    chk("mid_rdata", rdata, 32'hCAFE0002);
    aresetn = 1'b0;
    step();
    rready = 1'b0;
    chk("abort_rvalid", rvalid, 0);
    chk("abort_arready", arready, 0);
    chk("abort_rdata", rdata, 0);
    aresetn = 1'b1;
    step();
    chk("recover_arready", arready, 1);
    chk("recover_rvalid", rvalid, 0);
    do_burst(32'h40, 1, 2, 1, 1, -1, 0, 0);

    for (int t = 0; t < 40; t++) begin
      int sz, bu, ln;
      logic [31:0] ad;
      sz = $urandom_range(0, 3);
      bu = $urandom_range(0, 3);
      ln = $urandom_range(0, 15);
      ad = 32'($urandom_range(0, 32'h47F));
      if ($urandom_range(0, 1) == 1) ad = ad & ~((32'h1 << sz) - 1);
      do_burst(ad, ln, sz, bu, $urandom_range(1, 3), -1, 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
